// File: rtl/rtc_pkg.sv
// Shared types for the RTC edit controller: FSM states, field indices and the
// field-step helper used when walking left/right through the editable fields.
package rtc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [2:0] FLD_DAY    = 3'd0;
    localparam logic [2:0] FLD_MONTH  = 3'd1;
    localparam logic [2:0] FLD_YEAR   = 3'd2;
    localparam logic [2:0] FLD_HOUR   = 3'd3;
    localparam logic [2:0] FLD_MIN    = 3'd4;
    localparam logic [2:0] FLD_SEC    = 3'd5;
    localparam logic [2:0] FIELD_NONE = 3'd7;

    // Move one field forward or back, wrapping at both ends of 0..last.
    function automatic logic [2:0] field_step(input logic [2:0] cur,
                                              input logic       fwd,
                                              input logic [2:0] last);
        logic [2:0] nxt;
        if (fwd) begin
            nxt = (cur == last) ? FLD_DAY : cur + 3'd1;
        end else begin
            nxt = (cur == FLD_DAY) ? last : cur - 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rtc_edit_ctrl_btn_edge.sv
// btn_edge: one-bit rising-edge detector with registered history. After reset
// the detector stays disarmed until the button has been seen low once.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic evt
);

    logic prev_q, prev_d;
    logic armed_q, armed_d;

    always_comb begin
        prev_d  = btn;
        armed_d = armed_q | ~btn;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            armed_q <= armed_d;
        end
    end

    // A button held through reset release never looks like a fresh press.
    assign evt = btn & ~prev_q & armed_q;

endmodule

// File: rtl/rtc_edit_ctrl.sv
// RTC field-edit controller: IDLE -> EDIT -> COMMIT with registered outputs.
// Optional edit inactivity timeout is enabled by defining RTC_EDIT_TIMEOUT_EN.
module rtc_edit_ctrl
    import rtc_pkg::*;
#(
    parameter int unsigned NUM_FIELDS     = 6,
    parameter int unsigned TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       commit_ack,
    output logic [2:0] field_sel,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       edit_active,
    output logic       commit_req,
    output logic       abort_pulse,
    output logic [1:0] dbg_state
);

    if (NUM_FIELDS < 2 || NUM_FIELDS > 7) begin : g_bad_num_fields
        $error("rtc_edit_ctrl: NUM_FIELDS must be 2..7");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("rtc_edit_ctrl: TIMEOUT_CYCLES must be at least 2");
    end

    localparam logic [2:0] LAST_FLD = 3'(NUM_FIELDS - 1);

    logic ev_mode, ev_left, ev_right, ev_up, ev_down;

    btn_edge u_edge_mode  (.clk(clk), .rst(rst), .btn(btn_mode),  .evt(ev_mode));
    btn_edge u_edge_left  (.clk(clk), .rst(rst), .btn(btn_left),  .evt(ev_left));
    btn_edge u_edge_right (.clk(clk), .rst(rst), .btn(btn_right), .evt(ev_right));
    btn_edge u_edge_up    (.clk(clk), .rst(rst), .btn(btn_up),    .evt(ev_up));
    btn_edge u_edge_down  (.clk(clk), .rst(rst), .btn(btn_down),  .evt(ev_down));

    state_t     state_q, state_d;
    logic [2:0] field_q, field_d;
    logic       inc_q, inc_d;
    logic       dec_q, dec_d;
    logic       edit_q, edit_d;
    logic       commit_q, commit_d;
    logic       abort_q, abort_d;

`ifdef RTC_EDIT_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
    logic        any_evt;
    assign any_evt = ev_mode | ev_left | ev_right | ev_up | ev_down;
`endif

    always_comb begin
        state_d  = state_q;
        field_d  = field_q;
        inc_d    = 1'b0;
        dec_d    = 1'b0;
        edit_d   = edit_q;
        commit_d = commit_q;
        abort_d  = 1'b0;
`ifdef RTC_EDIT_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                field_d  = FIELD_NONE;
                edit_d   = 1'b0;
                commit_d = 1'b0;
`ifdef RTC_EDIT_TIMEOUT_EN
                tmo_d    = '0;
`endif
                if (ev_mode) begin
                    state_d = EDIT;
                    field_d = FLD_DAY;
                    edit_d  = 1'b1;
                end
            end
            EDIT: begin
                // Mode wins outright; anything arriving with it is dropped.
                if (ev_mode) begin
                    state_d  = COMMIT;
                    edit_d   = 1'b0;
                    commit_d = 1'b1;
                end else begin
                    if (ev_right && !ev_left) field_d = field_step(field_q, 1'b1, LAST_FLD);
                    if (ev_left && !ev_right) field_d = field_step(field_q, 1'b0, LAST_FLD);
                    inc_d = ev_up & ~ev_down;
                    dec_d = ev_down & ~ev_up;
`ifdef RTC_EDIT_TIMEOUT_EN
                    if (any_evt) begin
                        tmo_d = '0;
                    end else if (tmo_q == TIMEOUT_CYCLES - 1) begin
                        state_d = IDLE;
                        field_d = FIELD_NONE;
                        edit_d  = 1'b0;
                        abort_d = 1'b1;
                        tmo_d   = '0;
                    end else begin
                        tmo_d = tmo_q + 32'd1;
                    end
`endif
                end
            end
            COMMIT: begin
                commit_d = 1'b1;
                if (commit_ack) begin
                    state_d  = IDLE;
                    field_d  = FIELD_NONE;
                    commit_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                field_d  = FIELD_NONE;
                edit_d   = 1'b0;
                commit_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            field_q  <= FIELD_NONE;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            edit_q   <= 1'b0;
            commit_q <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            field_q  <= field_d;
            inc_q    <= inc_d;
            dec_q    <= dec_d;
            edit_q   <= edit_d;
            commit_q <= commit_d;
            abort_q  <= abort_d;
        end
    end

`ifdef RTC_EDIT_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`endif

    assign field_sel   = field_q;
    assign inc_pulse   = inc_q;
    assign dec_pulse   = dec_q;
    assign edit_active = edit_q;
    assign commit_req  = commit_q;
    assign dbg_state   = state_q;
`ifdef RTC_EDIT_TIMEOUT_EN
    assign abort_pulse = abort_q;
`else
    assign abort_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_edit_ctrl.sv
// Directed bench for rtc_edit_ctrl (NUM_FIELDS=6, TIMEOUT_CYCLES=16).
// The timeout section follows RTC_EDIT_TIMEOUT_EN the same way the design does.
module tb_rtc_edit_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, commit_ack = 1'b0;
    logic [2:0] field_sel;
    logic       inc_pulse, dec_pulse, edit_active, commit_req, abort_pulse;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;

    rtc_edit_ctrl #(.NUM_FIELDS(6), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_left(btn_left), .btn_right(btn_right),
        .btn_up(btn_up), .btn_down(btn_down), .commit_ack(commit_ack),
        .field_sel(field_sel), .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
        .edit_active(edit_active), .commit_req(commit_req),
        .abort_pulse(abort_pulse), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int n_inc, n_dec, n_commit, n_abort;

        // Reset state
        repeat (3) tick();
        chk("rst_field", field_sel, 7);
        chk("rst_outs", {inc_pulse, dec_pulse, edit_active, commit_req, abort_pulse}, 0);
        chk("rst_state", dbg_state, 0);
        rst = 1'b0;
        tick();

        // Enter EDIT, then left wraps 0 -> 5
        btn_mode = 1'b1; tick();
        chk("enter_field", field_sel, 0);
        chk("enter_edit", edit_active, 1);
        chk("enter_state", dbg_state, 1);
        btn_mode = 1'b0; tick();
        btn_left = 1'b1; tick();
        chk("left_wrap", field_sel, 5);
        btn_left = 1'b0; tick();

        // Right wraps 5 -> 0, then 0 -> 1
        btn_right = 1'b1; tick();
        chk("right_wrap", field_sel, 0);
        btn_right = 1'b0; tick();
        btn_right = 1'b1; tick();
        chk("right_step", field_sel, 1);
        btn_right = 1'b0; tick();

        // Left and right together: no change
        btn_left = 1'b1; btn_right = 1'b1; tick();
        chk("lr_same", field_sel, 1);
        btn_left = 1'b0; btn_right = 1'b0; tick();

        // Up held 10 cycles: exactly one inc pulse, on the first cycle
        n_inc = 0; n_dec = 0;
        btn_up = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) chk("up_first", inc_pulse, 1);
            n_inc += int'(inc_pulse);
            n_dec += int'(dec_pulse);
        end
        chk("up_held_count", n_inc, 1);
        chk("up_held_no_dec", n_dec, 0);
        btn_up = 1'b0; tick();

        // Down press: one dec pulse, gone the next cycle
        btn_down = 1'b1; tick();
        chk("down_pulse", {inc_pulse, dec_pulse}, 2'b01);
        tick();
        chk("down_single", dec_pulse, 0);
        btn_down = 1'b0; tick();

        // Up and down together: neither pulse
        btn_up = 1'b1; btn_down = 1'b1; tick();
        chk("ud_same", {inc_pulse, dec_pulse}, 2'b00);
        tick();
        chk("ud_same_after", {inc_pulse, dec_pulse}, 2'b00);
        btn_up = 1'b0; btn_down = 1'b0; tick();

        // Mode with right in the same cycle: commit, field kept
        btn_mode = 1'b1; btn_right = 1'b1; tick();
        chk("commit_req", commit_req, 1);
        chk("commit_field", field_sel, 1);
        chk("commit_edit_off", edit_active, 0);
        chk("commit_state", dbg_state, 2);
        btn_mode = 1'b0; btn_right = 1'b0;

        // Ack held low 20 cycles; button presses ignored meanwhile
        n_commit = 0; n_inc = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) btn_up = 1'b1;
            if (i == 8) btn_up = 1'b0;
            tick();
            n_commit += int'(commit_req);
            n_inc    += int'(inc_pulse);
        end
        chk("commit_hold", n_commit, 20);
        chk("commit_no_inc", n_inc, 0);
        chk("commit_field_hold", field_sel, 1);
        commit_ack = 1'b1; tick();
        chk("ack_req_low", commit_req, 0);
        chk("ack_field", field_sel, 7);
        chk("ack_state", dbg_state, 0);
        commit_ack = 1'b0; tick();

        // IDLE ignores non-mode buttons
        btn_up = 1'b1; btn_left = 1'b1; tick();
        chk("idle_ignore", {inc_pulse, edit_active, field_sel}, {1'b0, 1'b0, 3'd7});
        btn_up = 1'b0; btn_left = 1'b0; tick();

        // Inactivity behaviour
        btn_mode = 1'b1; tick();
        btn_mode = 1'b0;
        chk("tmo_enter", edit_active, 1);
`ifdef RTC_EDIT_TIMEOUT_EN
        n_abort = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            n_abort += int'(abort_pulse);
        end
        chk("tmo_early_abort", n_abort, 0);
        chk("tmo_still_edit", edit_active, 1);
        tick();
        chk("tmo_abort", abort_pulse, 1);
        chk("tmo_idle", {edit_active, commit_req, field_sel}, {1'b0, 1'b0, 3'd7});
        tick();
        chk("tmo_abort_single", abort_pulse, 0);
        chk("tmo_no_commit", commit_req, 0);
`else
        n_abort = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            n_abort += int'(abort_pulse);
        end
        chk("notmo_abort", n_abort, 0);
        chk("notmo_edit", edit_active, 1);
        chk("notmo_field", field_sel, 0);
        btn_mode = 1'b1; tick();
        btn_mode = 1'b0; commit_ack = 1'b1; tick();
        commit_ack = 1'b0;
        chk("notmo_exit", {edit_active, commit_req, field_sel}, {1'b0, 1'b0, 3'd7});
`endif
        tick();

        // Reset during COMMIT with up held
        btn_mode = 1'b1; tick();
        btn_mode = 1'b0; tick();
        btn_mode = 1'b1; tick();
        btn_mode = 1'b0;
        chk("pre_rst_commit", commit_req, 1);
        btn_up = 1'b1; tick();
        rst = 1'b1; tick();
        chk("rst_commit_field", field_sel, 7);
        chk("rst_commit_outs", {inc_pulse, dec_pulse, edit_active, commit_req, abort_pulse}, 0);
        chk("rst_commit_state", dbg_state, 0);
        tick();
        rst = 1'b0;
        n_commit = 0; n_inc = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_commit += int'(commit_req);
            n_inc    += int'(inc_pulse);
        end
        btn_mode = 1'b1; tick();
        btn_mode = 1'b0;
        chk("post_rst_edit", edit_active, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_commit += int'(commit_req);
            n_inc    += int'(inc_pulse);
        end
        chk("post_rst_no_commit", n_commit, 0);
        chk("post_rst_no_inc", n_inc, 0);
        btn_up = 1'b0; tick();
        btn_up = 1'b1; tick();
        chk("repress_inc", inc_pulse, 1);
        btn_up = 1'b0; tick();
        chk("repress_single", inc_pulse, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rtc_edit_ctrl.md
RTC_EDIT_CTRL -- requirements
Module: rtc_edit_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_FIELDS, default 6, giving the number of editable fields (0=day, 1=month, 2=year, 3=hour, 4=min, 5=sec); legal range 2..7.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 32'd1_000_000, giving the edit inactivity limit in clk cycles; legal minimum 2.
REQ-003 Port clk: input, 1 bit, system clock; all logic is on its rising edge.
REQ-004 Port rst: input, 1 bit, reset; synchronous, active-high.
REQ-005 Port btn_mode: input, 1 bit, level; enters edit mode, or commits when already editing.
REQ-006 Ports btn_left and btn_right: input, 1 bit each, level; select the previous or next field.
REQ-007 Ports btn_up and btn_down: input, 1 bit each, level; increment or decrement the selected field.
REQ-008 Port commit_ack: input, 1 bit; the downstream RTC writer accepts the commit.
REQ-009 Port field_sel: output, 3 bits; index of the field being edited, or 3'd7 when no field is selected.
REQ-010 Port inc_pulse / dec_pulse: output, 1 bit each; single-cycle step strobes to the field counters.
REQ-011 Port edit_active: output, 1 bit; high in EDIT state.
REQ-012 Port commit_req: output, 1 bit; commit request, held until acknowledged.
REQ-013 Port abort_pulse: output, 1 bit; single-cycle strobe on a timeout exit.

Function
REQ-014 Each button SHALL be converted to a rising-edge event: one event per low-to-high transition, however long the button is held.
REQ-015 Every output SHALL be registered; an event first sampled at clock edge k SHALL produce its response in the cycle after edge k.
REQ-016 The state machine SHALL have three states: IDLE, EDIT and COMMIT.
REQ-017 IDLE transitions: a mode event -> EDIT with field_sel=0; all other events are ignored.
REQ-018 EDIT, left/right: a right event SHALL set field_sel to field_sel+1, wrapping NUM_FIELDS-1 -> 0; a left event SHALL set field_sel to field_sel-1, wrapping 0 -> NUM_FIELDS-1.
REQ-019 EDIT, up/down: an up event SHALL pulse inc_pulse for one cycle; a down event SHALL pulse dec_pulse for one cycle.
REQ-020 EDIT, simultaneous events: up+down in the same cycle -> neither pulse; left+right in the same cycle -> no field change.
REQ-021 EDIT, mode event -> COMMIT; a mode event SHALL take priority over all other events in the same cycle, which are discarded.
REQ-022 COMMIT: commit_req=1 and field_sel keeps its last value; on commit_ack=1 -> IDLE with commit_req=0 in the next cycle; all button events are ignored.
REQ-023 field_sel SHALL be 3'd7 in IDLE.
REQ-024 inc_pulse and dec_pulse SHALL never both be high, and SHALL never be high outside EDIT.

Reset
REQ-025 rst SHALL force state=IDLE, field_sel=3'd7, all other outputs to 0, the edge-detect history to 0 and the timeout counter to 0.
REQ-026 rst SHALL take precedence over all events, including in EDIT or COMMIT, and no commit_req or abort_pulse SHALL follow it.
REQ-027 A button held high through reset release SHALL NOT generate an event until it has been released and pressed again.

Configuration
REQ-028 Macro RTC_EDIT_TIMEOUT_EN, when defined, SHALL enable an inactivity counter in EDIT.
REQ-029 With the macro: the counter clears on entry to EDIT and on any button event; on reaching TIMEOUT_CYCLES-1 with no event -> IDLE, abort_pulse=1 for one cycle, no commit.
REQ-030 Without the macro: EDIT SHALL persist indefinitely, abort_pulse SHALL be tied to 0 and the counter SHALL not exist.

Structure
REQ-031 Shared package rtc_pkg SHALL hold the state enum (IDLE, EDIT, COMMIT), the field index constants (FLD_DAY..FLD_SEC) and FIELD_NONE=3'd7.
REQ-032 One sub-module, btn_edge (single-bit registered rising-edge detector), SHALL be instantiated five times.

Verification
REQ-033 Hold btn_up high for 10 cycles in EDIT -> exactly one inc_pulse, one cycle after the first sampled high.
REQ-034 From IDLE: mode press, then left press -> field_sel goes 7 -> 0 -> 5 (NUM_FIELDS=6).
REQ-035 btn_up and btn_down rise in the same cycle in EDIT -> no inc_pulse and no dec_pulse.
REQ-036 Mode press in EDIT, commit_ack held low for 20 cycles then high -> commit_req high for 20+ cycles, then IDLE with field_sel=7.
REQ-037 With macro defined and TIMEOUT_CYCLES=16: enter EDIT, no input -> abort_pulse on the 16th cycle, then IDLE; without macro, still in EDIT after 1000 cycles.
REQ-038 Assert rst during COMMIT with btn_up held -> IDLE and all outputs 0; no inc_pulse after release until btn_up is re-pressed in EDIT.
